// File: rtl/guess_checker_pkg.sv
// Shared constants and types for the hangman guess engine: ASCII letter bounds and game states.
package guess_checker_pkg;

  localparam int unsigned ASCII_A      = 32'h41;
  localparam int unsigned ASCII_Z      = 32'h5A;
  localparam int unsigned N_LETTERS    = 26;
  localparam int unsigned LETTER_IDX_W = 5;
  localparam int unsigned MISS_W       = 4;
  localparam int unsigned DEF_WORD_LEN = 7;
  localparam int unsigned DEF_CHAR_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } game_state_e;

endpackage

// File: rtl/guess_checker_letter_match.sv
// Compares every word slot against one guessed code and flags which slots hold an upper-case letter.
module guess_checker_letter_match
  import guess_checker_pkg::*;
#(
  parameter int unsigned WORD_LEN = DEF_WORD_LEN,
  parameter int unsigned CHAR_W   = DEF_CHAR_W
) (
  input  logic [WORD_LEN*CHAR_W-1:0] word,
  input  logic [CHAR_W-1:0]          guess,
  output logic [WORD_LEN-1:0]        hit,
  output logic [WORD_LEN-1:0]        is_letter
);

  always_comb begin
    hit       = '0;
    is_letter = '0;
    for (int i = 0; i < int'(WORD_LEN); i++) begin
      hit[i]       = (word[CHAR_W*i +: CHAR_W] == guess);
      is_letter[i] = (word[CHAR_W*i +: CHAR_W] >= CHAR_W'(ASCII_A)) &&
                     (word[CHAR_W*i +: CHAR_W] <= CHAR_W'(ASCII_Z));
    end
  end

endmodule

// File: rtl/guess_checker.sv
// Hangman guess engine: latches the target word, scores letter guesses, tracks reveal/miss/used state.
// Optional macro GUESS_CHECKER_USED_OUT_EN exposes the used-letter vector as used_letters[25:0].
module guess_checker
  import guess_checker_pkg::*;
#(
  parameter int unsigned WORD_LEN   = DEF_WORD_LEN,
  parameter int unsigned MAX_MISSES = 6,
  parameter int unsigned CHAR_W     = DEF_CHAR_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       new_word,
  input  logic [WORD_LEN*CHAR_W-1:0] word_flat,
  input  logic                       guess_valid,
  input  logic [CHAR_W-1:0]          guess_ascii,
  output logic [WORD_LEN-1:0]        reveal_mask,
  output logic [MISS_W-1:0]          miss_count,
  output logic [1:0]                 game_state,
  output logic                       guess_ack,
  output logic                       dup_guess
`ifdef GUESS_CHECKER_USED_OUT_EN
  ,
  output logic [N_LETTERS-1:0]       used_letters
`endif
);

  localparam int unsigned WORD_W = WORD_LEN * CHAR_W;

  logic [WORD_W-1:0]       word_q;
  logic [WORD_W-1:0]       word_sel;
  logic [N_LETTERS-1:0]    used_q;
  game_state_e             state_q;
  logic [WORD_LEN-1:0]     hit;
  logic [WORD_LEN-1:0]     is_letter;
  logic                    guess_in_range;
  logic [LETTER_IDX_W-1:0] guess_idx;
  logic [WORD_LEN-1:0]     mask_hit;
  logic [MISS_W-1:0]       miss_nxt;

  // On load the matcher looks at the incoming word to find non-letter slots to pre-reveal.
  assign word_sel = new_word ? word_flat : word_q;

  guess_checker_letter_match #(
    .WORD_LEN (WORD_LEN),
    .CHAR_W   (CHAR_W)
  ) u_letter_match (
    .word      (word_sel),
    .guess     (guess_ascii),
    .hit       (hit),
    .is_letter (is_letter)
  );

  always_comb begin
    guess_in_range = (guess_ascii >= CHAR_W'(ASCII_A)) && (guess_ascii <= CHAR_W'(ASCII_Z));
    guess_idx      = LETTER_IDX_W'(guess_ascii - CHAR_W'(ASCII_A));
    mask_hit       = reveal_mask | hit;
    miss_nxt       = miss_count;
    if (hit == '0 && miss_count < MISS_W'(MAX_MISSES)) begin
      miss_nxt = miss_count + MISS_W'(1);
    end
  end

  assign game_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q      <= '0;
      used_q      <= '0;
      state_q     <= ST_IDLE;
      reveal_mask <= '0;
      miss_count  <= '0;
      guess_ack   <= 1'b0;
      dup_guess   <= 1'b0;
    end else begin
      guess_ack <= 1'b0;
      dup_guess <= 1'b0;
      if (new_word) begin
        word_q      <= word_flat;
        used_q      <= '0;
        miss_count  <= '0;
        reveal_mask <= ~is_letter;
        state_q     <= ST_PLAY;
      end else if (state_q == ST_PLAY && guess_valid && guess_in_range) begin
        if (used_q[guess_idx]) begin
          dup_guess <= 1'b1;
        end else begin
          used_q[guess_idx] <= 1'b1;
          guess_ack         <= 1'b1;
          miss_count        <= miss_nxt;
          // WIN outranks LOSE; losing exposes the whole answer.
          if (&mask_hit) begin
            reveal_mask <= mask_hit;
            state_q     <= ST_WIN;
          end else if (miss_nxt == MISS_W'(MAX_MISSES)) begin
            reveal_mask <= '1;
            state_q     <= ST_LOSE;
          end else begin
            reveal_mask <= mask_hit;
          end
        end
      end
    end
  end

`ifdef GUESS_CHECKER_USED_OUT_EN
  assign used_letters = used_q;
`endif

endmodule
